imem_fetch_port: RTL and testbench

//   Parametrised instruction memory with a synchronous, wait-stated read port.

---
 rtl/imem_fetch_port.sv | 110 +++++++++++
 tb/tb_imem_fetch_port.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_port.sv
// Instruction memory with a wait-stated valid/ready fetch port, a program-load
// write port and a flush input used to kill the in-flight fetch on redirects.
module imem_fetch_port #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INST_WIDTH  = 32,
    parameter int                    IMEM_DEPTH  = 1024,
    parameter int                    WAIT_STATES = 1,
    parameter logic [INST_WIDTH-1:0] NOP_INST    = 32'h00000013
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [INST_WIDTH-1:0]         rsp_inst,
    output logic [1:0]                    rsp_fault,
    input  logic                          flush,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [INST_WIDTH-1:0]         prog_data
);
    localparam int IDX_W  = $clog2(IMEM_DEPTH);
    localparam int WORD_W = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state, state_n;
    logic [3:0]              cnt, cnt_n;
    logic [ADDR_WIDTH-1:0]   addr_q, eff_addr;
    logic [WORD_W-1:0]       word;
    logic                    accept, enter_resp;
    logic [1:0]              fault_n;
    logic                    data_ok_q;
    logic [INST_WIDTH-1:0]   mem_q;
    logic [INST_WIDTH-1:0]   mem [IMEM_DEPTH];

    assign req_ready = !flush && (state == S_IDLE || (state == S_RESP && rsp_ready));
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == S_RESP);
    assign rsp_inst  = data_ok_q ? mem_q : NOP_INST;

    // With zero wait states RESP is entered on the accept edge itself, so the
    // read must use the incoming address rather than the registered one.
    assign eff_addr = accept ? req_addr : addr_q;
    assign word     = eff_addr[ADDR_WIDTH-1:2];

    always_comb begin
        fault_n = 2'b00;
        if (eff_addr[1:0] != 2'b00)
            fault_n = 2'b01;
        else if (word >= WORD_W'(IMEM_DEPTH))
            fault_n = 2'b10;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (flush) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    state_n = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                    cnt_n   = 4'(WAIT_STATES);
                end
                S_WAIT: begin
                    cnt_n = cnt - 4'd1;
                    if (cnt <= 4'd1) state_n = S_RESP;
                end
                S_RESP: if (rsp_ready) begin
                    if (accept) begin
                        state_n = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                        cnt_n   = 4'(WAIT_STATES);
                    end else begin
                        state_n = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
        enter_resp = (state_n == S_RESP) && (state != S_RESP || accept);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            addr_q    <= '0;
            rsp_fault <= 2'b00;
            data_ok_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) addr_q <= req_addr;
            if (enter_resp) begin
                rsp_fault <= fault_n;
                data_ok_q <= (fault_n == 2'b00);
            end
        end
    end

    // Array kept reset-free so it maps onto block RAM; a same-edge write is
    // not visible to the read, which returns the old word.
    always_ff @(posedge clk) begin
        if (prog_we) mem[prog_addr] <= prog_data;
        if (enter_resp) mem_q <= mem[word[IDX_W-1:0]];
    end
endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed bench for imem_fetch_port: one instance with one wait state, one with none.
module tb_imem_fetch_port;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance a: WAIT_STATES=1
    logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, flush = 0, prog_we = 0;
    logic [31:0] req_addr = 0, rsp_inst, prog_data = 0;
    logic [1:0]  rsp_fault;
    logic [9:0]  prog_addr = 0;
    // instance b: WAIT_STATES=0
    logic        b_req_valid = 0, b_req_ready, b_rsp_valid, b_rsp_ready = 0, b_flush = 0, b_prog_we = 0;
    logic [31:0] b_req_addr = 0, b_rsp_inst, b_prog_data = 0;
    logic [1:0]  b_rsp_fault;
    logic [9:0]  b_prog_addr = 0;

    imem_fetch_port #(.WAIT_STATES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_inst(rsp_inst), .rsp_fault(rsp_fault), .flush(flush),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data));

    imem_fetch_port #(.WAIT_STATES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_addr(b_req_addr), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_inst(b_rsp_inst), .rsp_fault(b_rsp_fault), .flush(b_flush),
        .prog_we(b_prog_we), .prog_addr(b_prog_addr), .prog_data(b_prog_data));

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_a(input int idx, input logic [31:0] d);
        @(negedge clk);
        prog_we = 1; prog_addr = 10'(idx); prog_data = d;
        @(negedge clk);
        prog_we = 0;
    endtask

    task automatic load_b(input int idx, input logic [31:0] d);
        @(negedge clk);
        b_prog_we = 1; b_prog_addr = 10'(idx); b_prog_data = d;
        @(negedge clk);
        b_prog_we = 0;
    endtask

    // Single fetch from idle on instance a; checks latency, data and fault.
    task automatic fetch_a(input string name, input logic [31:0] addr,
                           input logic [31:0] exp_inst, input logic [1:0] exp_fault);
        int lat;
        @(negedge clk);
        req_valid = 1; req_addr = addr; rsp_ready = 0;
        chk({name, ".req_ready"}, 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, ".latency"}, 64'(lat), 64'd2);
        chk({name, ".inst"}, 64'(rsp_inst), 64'(exp_inst));
        chk({name, ".fault"}, 64'(rsp_fault), 64'(exp_fault));
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk({name, ".drop"}, 64'(rsp_valid), 64'd0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] inst;
        logic [1:0]  fault;
    } vec_t;

    vec_t vecs[8];
    logic [31:0] w [4];
    logic [31:0] exp3 [3];

    initial begin
        w[0] = 32'h00100093; w[1] = 32'h00200113; w[2] = 32'h00C00193; w[3] = 32'h00400213;
        vecs[0] = '{"w2",      32'd8,    w[2],         2'b00};
        vecs[1] = '{"w0",      32'd0,    w[0],         2'b00};
        vecs[2] = '{"w1",      32'd4,    w[1],         2'b00};
        vecs[3] = '{"last",    32'd4092, 32'hDEADBEEF, 2'b00};
        vecs[4] = '{"mis6",    32'd6,    NOP,          2'b01};
        vecs[5] = '{"oor4096", 32'd4096, NOP,          2'b10};
        vecs[6] = '{"mis4097", 32'd4097, NOP,          2'b01};
        vecs[7] = '{"mis2",    32'd2,    NOP,          2'b01};

        repeat (3) @(negedge clk);
        chk("reset.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset.rsp_inst", 64'(rsp_inst), 64'(NOP));
        chk("reset.rsp_fault", 64'(rsp_fault), 64'd0);
        chk("reset.req_ready", 64'(req_ready), 64'd1);
        rst_n = 1;

        for (int i = 0; i < 4; i++) load_a(i, w[i]);
        load_a(1023, 32'hDEADBEEF);

        for (int i = 0; i < 8; i++) fetch_a(vecs[i].name, vecs[i].addr, vecs[i].inst, vecs[i].fault);

        // back-to-back 0,4,8 then a 3-cycle stall
        exp3[0] = w[0]; exp3[1] = w[1]; exp3[2] = w[2];
        @(negedge clk);
        req_valid = 1; req_addr = 0; rsp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("b2b%0d.wait", i), 64'(rsp_valid), 64'd0);
            if (i < 2) req_addr = 32'(4 * (i + 1));
            else begin req_valid = 0; rsp_ready = 0; end
            @(negedge clk);
            chk($sformatf("b2b%0d.valid", i), 64'(rsp_valid), 64'd1);
            chk($sformatf("b2b%0d.inst", i), 64'(rsp_inst), 64'(exp3[i]));
        end
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk($sformatf("stall%0d.valid", s), 64'(rsp_valid), 64'd1);
            chk($sformatf("stall%0d.inst", s), 64'(rsp_inst), 64'(w[2]));
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("stall.release", 64'(rsp_valid), 64'd0);

        // flush in WAIT
        @(negedge clk);
        req_valid = 1; req_addr = 4;
        @(negedge clk);
        req_valid = 0; flush = 1;
        @(negedge clk);
        flush = 0;
        #1 chk("flush_wait.req_ready", 64'(req_ready), 64'd1);
        chk("flush_wait.valid", 64'(rsp_valid), 64'd0);
        repeat (2) begin
            @(negedge clk);
            chk("flush_wait.none", 64'(rsp_valid), 64'd0);
        end

        // flush in RESP with rsp_ready and a new request
        @(negedge clk);
        req_valid = 1; req_addr = 0;
        @(negedge clk);
        req_addr = 4;
        @(negedge clk);
        chk("flush_resp.valid_before", 64'(rsp_valid), 64'd1);
        rsp_ready = 1; flush = 1;
        #1 chk("flush_resp.req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        flush = 0; req_valid = 0; rsp_ready = 0;
        chk("flush_resp.valid", 64'(rsp_valid), 64'd0);
        #1 chk("flush_resp.idle", 64'(req_ready), 64'd1);
        repeat (2) begin
            @(negedge clk);
            chk("flush_resp.none", 64'(rsp_valid), 64'd0);
        end

        // write/read collision on word 3
        @(negedge clk);
        req_valid = 1; req_addr = 12;
        @(negedge clk);
        req_valid = 0; prog_we = 1; prog_addr = 10'd3; prog_data = 32'hCAFE0013;
        @(negedge clk);
        prog_we = 0;
        chk("collide.old", 64'(rsp_inst), 64'(w[3]));
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        fetch_a("refetch", 32'd12, 32'hCAFE0013, 2'b00);

        // reset while mid-WAIT
        @(negedge clk);
        req_valid = 1; req_addr = 8;
        @(negedge clk);
        req_valid = 0;
        #2 rst_n = 0;
        #1 chk("rst_mid.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_mid.rsp_inst", 64'(rsp_inst), 64'(NOP));
        chk("rst_mid.req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_mid.no_rsp", 64'(rsp_valid), 64'd0);
        chk("rst_mid.inst_after", 64'(rsp_inst), 64'(NOP));

        // zero wait states: latency 1, back-to-back, collision
        load_b(5, 32'h00500293);
        load_b(6, 32'h00600313);
        @(negedge clk);
        b_req_valid = 1; b_req_addr = 20; b_rsp_ready = 0;
        @(negedge clk);
        chk("ws0.lat1", 64'(b_rsp_valid), 64'd1);
        chk("ws0.inst5", 64'(b_rsp_inst), 64'h00500293);
        b_rsp_ready = 1; b_req_addr = 24;
        @(negedge clk);
        chk("ws0.b2b.valid", 64'(b_rsp_valid), 64'd1);
        chk("ws0.b2b.inst6", 64'(b_rsp_inst), 64'h00600313);
        b_req_addr = 20; b_prog_we = 1; b_prog_addr = 10'd5; b_prog_data = 32'h12345013;
        @(negedge clk);
        chk("ws0.collide.old", 64'(b_rsp_inst), 64'h00500293);
        b_prog_we = 0; b_req_addr = 22;
        @(negedge clk);
        chk("ws0.mis.fault", 64'(b_rsp_fault), 64'd1);
        chk("ws0.mis.inst", 64'(b_rsp_inst), 64'(NOP));
        b_req_addr = 20;
        @(negedge clk);
        chk("ws0.new", 64'(b_rsp_inst), 64'h12345013);
        b_req_valid = 0;
        @(negedge clk);
        b_rsp_ready = 0;
        chk("ws0.idle", 64'(b_rsp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
